// File: rtl/port_reorder_fifo_if.sv
// Bundle of the handshake, data and status signals of port_reorder_fifo.
//   master: group producer / result consumer (drives in_*, out_ack)
//   slave : the reorder FIFO itself
// Signals:
//   in_stb, in_ready          input group handshake
//   in_ids, in_data, in_lvalid lane i at [i*W +: W]
//   out_stb, out_ack          head group handshake
//   out_data, out_lvalid      slot k = lane whose original ID is k
//   perm_err, err_count       bad-permutation pulse and saturating count
//   level                     FIFO occupancy
interface port_reorder_fifo_if #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ERR_W     = 8
);
  logic                        in_stb;
  logic                        in_ready;
  logic [NUM_PORTS*ID_W-1:0]   in_ids;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0]        in_lvalid;
  logic                        out_stb;
  logic                        out_ack;
  logic [NUM_PORTS*DATA_W-1:0] out_data;
  logic [NUM_PORTS-1:0]        out_lvalid;
  logic                        perm_err;
  logic [ERR_W-1:0]            err_count;
  logic [$clog2(DEPTH):0]      level;

  modport master (
    output in_stb, in_ids, in_data, in_lvalid, out_ack,
    input  in_ready, out_stb, out_data, out_lvalid, perm_err, err_count, level
  );

  modport slave (
    input  in_stb, in_ids, in_data, in_lvalid, out_ack,
    output in_ready, out_stb, out_data, out_lvalid, perm_err, err_count, level
  );
endinterface

// File: rtl/port_reorder_fifo.sv
// Reorders one group of NUM_PORTS lane results back to original-port slots and
// queues the reordered groups in a DEPTH-entry FIFO.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    port_reorder_fifo_if.slave: in_stb/in_ready/in_ids/in_data/in_lvalid,
//          out_stb/out_ack/out_data/out_lvalid, perm_err, err_count, level
// Groups whose IDs are not a permutation of 0..NUM_PORTS-1 are still queued, but
// with all data and lane-valid bits cleared, and are counted in err_count.
module port_reorder_fifo #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ERR_W     = 8
) (
  input logic               clk,
  input logic               rst_n,
  port_reorder_fifo_if.slave bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned DBITS   = NUM_PORTS * DATA_W;
  localparam int unsigned ENTRY_W = DBITS + NUM_PORTS;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q;
  logic                 perm_err_q;
  logic [ERR_W-1:0]     err_count_q;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];

  logic                 perm_ok;
  logic [DBITS-1:0]     wr_data;
  logic [NUM_PORTS-1:0] wr_lvalid;
  logic                 in_ready, out_stb, push, pop;
  logic [ENTRY_W-1:0]   head;

  // Permutation check covers every lane, whether or not its lane-valid is set.
  always_comb begin
    perm_ok = 1'b1;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (int'(bus.in_ids[i*ID_W +: ID_W]) >= int'(NUM_PORTS)) perm_ok = 1'b0;
      for (int j = i + 1; j < int'(NUM_PORTS); j++) begin
        if (bus.in_ids[i*ID_W +: ID_W] == bus.in_ids[j*ID_W +: ID_W]) perm_ok = 1'b0;
      end
    end
  end

  // Slot k gathers the lane that carries ID k; a bad group is written as all zero.
  always_comb begin
    wr_data   = '0;
    wr_lvalid = '0;
    if (perm_ok) begin
      for (int k = 0; k < int'(NUM_PORTS); k++) begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
          if (bus.in_ids[i*ID_W +: ID_W] == ID_W'(k)) begin
            wr_data[k*DATA_W +: DATA_W] = bus.in_data[i*DATA_W +: DATA_W];
            wr_lvalid[k]                = bus.in_lvalid[i];
          end
        end
      end
    end
  end

  // in_ready comes from registered occupancy only, so a pop never opens a slot
  // for a push in the same cycle.
  assign in_ready = (level_q != FULL_LVL);
  assign out_stb  = (level_q != '0);
  assign push     = bus.in_stb && in_ready;
  assign pop      = out_stb && bus.out_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      perm_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: ;
      endcase
      perm_err_q <= push && !perm_ok;
      if (push && !perm_ok && (err_count_q != ERR_MAX)) begin
        err_count_q <= err_count_q + ERR_W'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_lvalid, wr_data};
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.in_ready   = in_ready;
  assign bus.out_stb    = out_stb;
  assign bus.out_data   = out_stb ? head[DBITS-1:0] : '0;
  assign bus.out_lvalid = out_stb ? head[ENTRY_W-1:DBITS] : '0;
  assign bus.perm_err   = perm_err_q;
  assign bus.err_count  = err_count_q;
  assign bus.level      = level_q;
endmodule
